// File: rtl/tpu_pkg.sv
// Shared TPU constants and the FC layer state encoding.
// Imported by fc_requant and fc_layer_engine.
package tpu_pkg;

    localparam int LANES  = 128;
    localparam int ROW_W  = 1024;
    localparam int SUM_W  = 15;
    localparam int ADDR_W = 11;
    localparam int J_W    = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ACC   = 3'd3,
        S_DONE  = 3'd4
    } fc_state_e;

endpackage

// File: rtl/fc_requant.sv
// Requantizer: arithmetic shift then clamp to 8 bits with a clamp flag.
// FC_RELU_EN selects ReLU clamping; otherwise signed saturation.
module fc_requant
    import tpu_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic signed [SUM_W-1:0] sum,
    output logic        [7:0]       q,
    output logic                    clamp
);

    localparam logic signed [SUM_W-1:0] QMAX = SUM_W'(127);
`ifndef FC_RELU_EN
    localparam logic signed [SUM_W-1:0] QMIN = SUM_W'(-128);
`endif

    logic signed [SUM_W-1:0] s;

    assign s = sum >>> SHIFT;

    always_comb begin
        q     = s[7:0];
        clamp = 1'b0;
`ifdef FC_RELU_EN
        // negatives flush to zero silently; only positive clipping is flagged
        if (s[SUM_W-1]) begin
            q = 8'h00;
        end else if (s > QMAX) begin
            q     = 8'h7f;
            clamp = 1'b1;
        end
`else
        if (s > QMAX) begin
            q     = 8'h7f;
            clamp = 1'b1;
        end else if (s < QMIN) begin
            q     = 8'h80;
            clamp = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/fc_layer_engine.sv
// FC layer engine: walks N_OUT ROM rows through the shared MultAdder.
// Requant mode selected by FC_RELU_EN (see fc_requant).
module fc_layer_engine
    import tpu_pkg::*;
#(
    parameter int N_OUT    = 128,
    parameter int ROM_BASE = 0,
    parameter int SHIFT    = 0
) (
    input  logic                    clk,
    input  logic                    iRst,
    input  logic                    ena,
    input  logic [ROW_W-1:0]        data_from_rom,
    input  logic [ROW_W-1:0]        data_from_ram,
    input  logic signed [SUM_W-1:0] data_from_MultAdder,
    input  logic                    overflow_from_MultAdder,
    output logic [ADDR_W-1:0]       addr_to_rom,
    output logic [ROW_W-1:0]        opr1_to_MultAdder,
    output logic [ROW_W-1:0]        opr2_to_MultAdder,
    output logic [N_OUT*8-1:0]      data_to_ram,
    output logic                    overflow,
    output logic                    done
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ROM_BASE);
    localparam logic [J_W-1:0]    LAST = J_W'(N_OUT - 1);

    fc_state_e      state_q;
    fc_state_e      state_d;
    logic [J_W-1:0] j_q;
    logic [7:0]     rq_byte;
    logic           rq_clamp;

    fc_requant #(
        .SHIFT(SHIFT)
    ) u_requant (
        .sum  (data_from_MultAdder),
        .q    (rq_byte),
        .clamp(rq_clamp)
    );

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ena) state_d = S_FETCH;
            S_FETCH: state_d = ena ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = ena ? S_ACC : S_IDLE;
            S_ACC: begin
                if (!ena)            state_d = S_IDLE;
                else if (j_q == LAST) state_d = S_DONE;
                else                 state_d = S_FETCH;
            end
            S_DONE:  if (!ena) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            j_q               <= '0;
            addr_to_rom       <= BASE;
            opr1_to_MultAdder <= '0;
            opr2_to_MultAdder <= '0;
            data_to_ram       <= '0;
            overflow          <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= (state_d == S_DONE);
            unique case (state_q)
                S_IDLE: begin
                    if (ena) begin
                        opr1_to_MultAdder <= data_from_ram;
                        j_q               <= '0;
                        addr_to_rom       <= BASE;
                        overflow          <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ena) opr2_to_MultAdder <= data_from_rom;
                end
                S_ACC: begin
                    if (ena) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (j_q == J_W'(k)) data_to_ram[8*k +: 8] <= rq_byte;
                        end
                        overflow <= overflow | overflow_from_MultAdder | rq_clamp;
                        if (j_q != LAST) begin
                            j_q         <= j_q + 1'b1;
                            addr_to_rom <= addr_to_rom + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine (N_OUT=10, ROM_BASE=640, SHIFT 0 and 2).
module tb_fc_layer_engine;

    localparam int NO = 10;
    localparam int RB = 640;

    typedef struct {
        logic [79:0] b0;
        logic [79:0] b2;
        logic        o0;
        logic        o2;
        int          start;
    } exp_t;

    logic          clk = 1'b0;
    logic          iRst;
    logic          ena;
    logic          inj;
    logic [1023:0] act;
    logic [1023:0] rows [0:2047];
    logic [1023:0] rom_q;

    logic [10:0]   addr0, addr2;
    logic [1023:0] o1_0, o2_0, o1_2, o2_2;
    logic [79:0]   ram0, ram2;
    logic          ovf0, ovf2, done0, done2;
    logic [14:0]   ma_s0, ma_s2;
    logic          ma_o0, ma_o2;
    int            full0, full2;

    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    exp_t sb[$];
    exp_t last;
    exp_t me;
    int   mrel;
    logic dprev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    fc_layer_engine #(.N_OUT(NO), .ROM_BASE(RB), .SHIFT(0)) dut0 (
        .clk(clk), .iRst(iRst), .ena(ena),
        .data_from_rom(rom_q), .data_from_ram(act),
        .data_from_MultAdder(ma_s0), .overflow_from_MultAdder(ma_o0),
        .addr_to_rom(addr0), .opr1_to_MultAdder(o1_0),
        .opr2_to_MultAdder(o2_0), .data_to_ram(ram0),
        .overflow(ovf0), .done(done0)
    );

    fc_layer_engine #(.N_OUT(NO), .ROM_BASE(RB), .SHIFT(2)) dut2 (
        .clk(clk), .iRst(iRst), .ena(ena),
        .data_from_rom(rom_q), .data_from_ram(act),
        .data_from_MultAdder(ma_s2), .overflow_from_MultAdder(ma_o2),
        .addr_to_rom(addr2), .opr1_to_MultAdder(o1_2),
        .opr2_to_MultAdder(o2_2), .data_to_ram(ram2),
        .overflow(ovf2), .done(done2)
    );

    function automatic int dot(input logic [1023:0] x, input logic [1023:0] y);
        int acc = 0;
        for (int l = 0; l < 128; l++)
            acc += int'($signed(x[8*l +: 8])) * int'($signed(y[8*l +: 8]));
        return acc;
    endfunction

    // environment: one-cycle ROM and combinational MultAdder
    always @(posedge clk) rom_q <= rows[addr0];
    always_comb full0 = dot(o1_0, o2_0);
    always_comb full2 = dot(o1_2, o2_2);
    assign ma_s0 = full0[14:0];
    assign ma_s2 = full2[14:0];
    assign ma_o0 = (full0 > 16383) || (full0 < -16384) || inj;
    assign ma_o2 = (full2 > 16383) || (full2 < -16384) || inj;

    function automatic void req(input int sum, input int sh,
                                output logic [7:0] q, output logic cl);
        int s;
        s  = sum >>> sh;
        cl = 1'b0;
`ifdef FC_RELU_EN
        if (s < 0) q = 8'h00;
        else if (s > 127) begin q = 8'h7f; cl = 1'b1; end
        else q = s[7:0];
`else
        if (s > 127) begin q = 8'h7f; cl = 1'b1; end
        else if (s < -128) begin q = 8'h80; cl = 1'b1; end
        else q = s[7:0];
`endif
    endfunction

    function automatic exp_t model(input logic force_ovf);
        exp_t e;
        int full, t;
        logic signed [14:0] t15;
        logic [7:0] q;
        logic cl, mao;
        e.b0 = '0; e.b2 = '0;
        e.o0 = force_ovf; e.o2 = force_ovf;
        e.start = 0;
        for (int j = 0; j < NO; j++) begin
            full = dot(act, rows[RB + j]);
            t15  = full[14:0];
            t    = int'(t15);
            mao  = (full != t);
            req(t, 0, q, cl);
            e.b0[8*j +: 8] = q;
            e.o0 = e.o0 | mao | cl;
            req(t, 2, q, cl);
            e.b2[8*j +: 8] = q;
            e.o2 = e.o2 | mao | cl;
        end
        return e;
    endfunction

    task automatic chk(input string n, input logic [79:0] got, input logic [79:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endtask

    task automatic clr_rows();
        for (int j = 0; j < NO; j++) rows[RB + j] = '0;
    endtask

    task automatic fill(input int mode);
        act = '0;
        clr_rows();
        for (int l = 0; l < 128; l++) begin
            if (mode == 1) act[8*l +: 8] = 8'($urandom);
            else if (mode == 0) act[8*l +: 8] = 8'($urandom_range(0, 15) - 8);
        end
        if (mode == 2) act[7:0] = 8'($urandom_range(0, 20) - 10);
        for (int j = 0; j < NO; j++)
            for (int l = 0; l < 128; l++) begin
                if (mode == 1) rows[RB + j][8*l +: 8] = 8'($urandom);
                else if (mode == 0) rows[RB + j][8*l +: 8] = 8'($urandom_range(0, 15) - 8);
                else if (l == 0) rows[RB + j][7:0] = 8'($urandom_range(0, 20) - 10);
            end
    endtask

    task automatic run(input logic force_ovf, input int inj_on);
        exp_t e;
        int rel;
        logic hit;
        e = model(force_ovf);
        @(negedge clk);
        ena = 1'b1;
        e.start = edge_n + 1;
        sb.push_back(e);
        last = e;
        hit = 1'b0;
        for (int k = 0; k < 45 && !hit; k++) begin
            @(negedge clk);
            rel = edge_n - e.start + 1;
            if (rel == 1) chk("ovf_clear_at_start", 80'(ovf0), 80'(0));
            if (inj_on > 0 && rel == inj_on) begin
                chk("ovf_before_pulse", 80'(ovf0), 80'(0));
                inj = 1'b1;
            end
            if (inj_on > 0 && rel == inj_on + 1) begin
                inj = 1'b0;
                chk("ovf_after_pulse", 80'(ovf0), 80'(force_ovf));
            end
            if (done0) hit = 1'b1;
        end
        if (!hit) chk("done_timeout", 80'(0), 80'(1));
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("done_cleared", 80'(done0), 80'(0));
    endtask

    // monitor: done rising pops the scoreboard; address walk checked while busy
    always @(negedge clk) begin
        if (!iRst) begin
            if (done0 && !dprev) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 80'(1), 80'(0));
                end else begin
                    me = sb.pop_front();
                    chk("done_edge", 80'(edge_n - me.start + 1), 80'(31));
                    chk("bytes_shift0", ram0, me.b0);
                    chk("bytes_shift2", ram2, me.b2);
                    chk("ovf_shift0", 80'(ovf0), 80'(me.o0));
                    chk("ovf_shift2", 80'(ovf2), 80'(me.o2));
                    chk("done_shift2", 80'(done2), 80'(1));
                end
            end
            if (sb.size() > 0) begin
                mrel = edge_n - sb[0].start + 1;
                if (mrel >= 1 && mrel <= 30) begin
                    chk("addr_walk", 80'(addr0), 80'(RB + (mrel - 1) / 3));
                    chk("addr_walk_s2", 80'(addr2), 80'(RB + (mrel - 1) / 3));
                end
            end
        end
        dprev = done0;
    end

    task automatic chk_reset(input string n);
        chk({n, "_addr"}, 80'(addr0), 80'(RB));
        chk({n, "_opr1"}, 80'(o1_0 != 0), 80'(0));
        chk({n, "_opr2"}, 80'(o2_0 != 0), 80'(0));
        chk({n, "_ram"}, ram0 | ram2, 80'(0));
        chk({n, "_ovf"}, 80'({ovf0, ovf2}), 80'(0));
        chk({n, "_done"}, 80'({done0, done2}), 80'(0));
    endtask

    initial begin
        exp_t ea;
        iRst = 1'b1; ena = 1'b0; inj = 1'b0; act = '0;
        for (int a = 0; a < 2048; a++) rows[a] = '0;
        #12;
        chk_reset("reset");
        @(negedge clk);
        iRst = 1'b0;

        act = '0; act[7:0] = 8'd3;
        for (int j = 0; j < NO; j++) rows[RB + j][7:0] = 8'(j);
        run(1'b0, 0);
        chk("lane0_ramp", ram0, 80'h1b_18_15_12_0f_0c_09_06_03_00);

        act = '0; act[7:0] = 8'd5;
        clr_rows(); rows[RB][7:0] = 8'hff;
        run(1'b0, 0);

        act = '0;
        for (int l = 0; l < 10; l++) act[8*l +: 8] = 8'd100;
        act[87:80] = 8'd5;
        clr_rows();
        for (int l = 0; l < 3; l++) rows[RB][8*l +: 8] = 8'd1;
        for (int l = 0; l < 10; l++) rows[RB + 1][8*l +: 8] = 8'd1;
        rows[RB + 2][87:80] = 8'hff;
        run(1'b0, 0);
        chk("shift2_300_1000", 80'(ram2[15:0]), 80'(16'h7f4b));

        fill(2);
        run(1'b1, 15);
        fill(2);
        run(1'b0, 16);

        fill(0);
        ea = model(1'b0);
        @(negedge clk);
        ena = 1'b1;
        ea.start = edge_n + 1;
        while (edge_n - ea.start + 1 < 9) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 80'(done0), 80'(0));
        chk("abort_bytes01", 80'(ram0[15:0]), 80'(ea.b0[15:0]));
        chk("abort_keep_rest", 80'(ram0[79:16]), 80'(last.b0[79:16]));
        chk("abort_keep_rest_s2", 80'(ram2[79:16]), 80'(last.b2[79:16]));
        @(negedge clk);
        run(1'b0, 0);

        for (int r = 0; r < 8; r++) begin
            fill(r % 2);
            run(1'b0, 0);
        end

        fill(0);
        @(negedge clk);
        ena = 1'b1;
        ea.start = edge_n + 1;
        while (edge_n - ea.start + 1 < 6) @(negedge clk);
        #1 iRst = 1'b1;
        #1 chk_reset("midrun_reset");
        ena = 1'b0;
        @(negedge clk);
        iRst = 1'b0;
        run(1'b0, 0);

        chk("scoreboard_empty", 80'(sb.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

Fully-connected layer responder driven by the TPU sequencer's per-layer `ena`/`done` handshake. While enabled, it walks N_OUT weight rows from the shared block ROM and presents each row plus the latched activation vector to the shared 128-lane MultAdder. It requantizes each 15-bit dot product to 8 bits and raises `done` when the output vector is complete. One instance serves as FC1 (N_OUT=128) and another as FC2 (N_OUT=10); the sequencer owns all bus muxing.

## Interface
Parameters:
- N_OUT, 128: output neurons, equal to the number of ROM rows consumed; range 1..128.
- ROM_BASE, 0: ROM address of weight row 0; ROM_BASE+N_OUT-1 ≤ 2047.
- SHIFT, 0: arithmetic right shift applied to each sum before clamping; range 0..7.

Ports:
- clk  in  1  rising-edge clock.
- iRst  in  1  asynchronous, active-high reset.
- ena  in  1  level; held high by the sequencer for the whole layer.
- data_from_rom  in  1024  weight row, 128 signed bytes; valid one cycle after the address is sampled.
- data_from_ram  in  1024  activation vector, 128 signed bytes.
- data_from_MultAdder  in  15  signed dot product of opr1 and opr2; combinational.
- overflow_from_MultAdder  in  1  MultAdder overflow for the current operands.
- addr_to_rom  out  11  registered ROM address.
- opr1_to_MultAdder  out  1024  registered activations.
- opr2_to_MultAdder  out  1024  registered weight row.
- data_to_ram  out  N_OUT*8  result vector; byte j is at [8j+7:8j].
- overflow  out  1  sticky error flag for the current run.
- done  out  1  result vector complete.

## Operation
- States: IDLE, FETCH, LOAD, ACC, DONE. Row counter j spans 0..N_OUT-1.
- IDLE, ena=1: latch data_from_ram into opr1. Set j=0, addr_to_rom=ROM_BASE, overflow=0. Go to FETCH.
- FETCH: the ROM samples the address. Go to LOAD.
- LOAD: capture data_from_rom into opr2. Go to ACC.
- ACC: read data_from_MultAdder, requantize it, and write the result to byte j. Then OR overflow_from_MultAdder and the clamp flag into overflow.
  - If j = N_OUT-1, go to DONE.
  - Otherwise set j+1 and addr_to_rom+1, and go to FETCH.
- DONE: hold done=1 while ena=1. When ena=0, go to IDLE and set done=0.
- ena=0 in any state except IDLE returns to IDLE on the next edge.
  - done stays 0.
  - data_to_ram keeps the bytes already written.
  - overflow holds its value until the next start.
- Requantization:
  - s = sum >>> SHIFT (sign-preserving).
  - s is clamped per the Configuration section.
  - The clamp flag is 1 whenever clamping changed a positive value.
- data_to_ram is not cleared at start; every byte is rewritten during a full run.

## Timing
- Edge 1 is the first rising edge with ena=1 in IDLE.
- Each row takes 3 cycles. Byte j is written at edge 3j+4.
- done rises at edge 3·N_OUT+1: edge 31 for N_OUT=10, edge 385 for N_OUT=128.
- addr_to_rom holds ROM_BASE+j from edge 3j+1 through edge 3j+3.
- Reset values, applied asynchronously by iRst:
  - state=IDLE, j=0
  - addr_to_rom=ROM_BASE
  - opr1, opr2, data_to_ram = 0
  - overflow=0, done=0
- iRst has priority over ena in every state, including reset mid-run.
- overflow_from_MultAdder is sampled only in ACC; pulses in other states are ignored.

## Configuration
- FC_RELU_EN defined: ReLU. s<0 gives 0; s>127 gives 127 with the clamp flag set.
- FC_RELU_EN undefined: signed saturation to −128..127. The clamp flag is set on either bound.

## Structure
- Shared package tpu_pkg holds:
  - LANES=128, ROW_W=1024, SUM_W=15, ADDR_W=11
  - the state enum encoding
- Sub-module fc_requant: combinational shift, clamp and clamp flag, 15-bit in, 8-bit plus flag out. Parameterized by SHIFT, with FC_RELU_EN handled inside.

## Test plan
- N_OUT=10, ROM_BASE=640, ROM row j has every weight 0 except lane 0 = j, activations lane 0 = 3, bench MultAdder model:
  - addr_to_rom steps 640..649, each address held 3 cycles.
  - data_to_ram bytes = 0,3,6,…,27.
  - done rises at edge 31; overflow=0.
- Sum −5 with SHIFT=0:
  - FC_RELU_EN defined → byte 0x00, overflow=0.
  - FC_RELU_EN undefined → byte 0xFB, overflow=0.
- SHIFT=2: sum 300 → 75 (0x4B). Sum 1000 → 127 (0x7F) with overflow=1.
- overflow_from_MultAdder=1 only during row 4's ACC cycle:
  - overflow=1 from edge 16 through done.
  - A fresh run with ena dropped and then raised clears overflow at edge 1.
- ena dropped at edge 10, then re-raised 2 cycles later:
  - done never rises in the first attempt.
  - The second run completes at edge 31 relative to its own start, with correct bytes.
- iRst asserted between edges during ACC:
  - All outputs reach reset values before the next clock edge.
  - After iRst deasserts, ena=1 starts a normal run.
